rect_fill_engine: RTL
=====================

# rect_fill_engine

Rectangle fill engine downstream of the EPP register interface. It latches the corner coordinates and fill value on a `start_fill` pulse. It then walks every pixel of the inclusive rectangle row by row and issues one-pixel writes to the 320x200 monochrome framebuffer port. A stall handshake lets the framebuffer arbiter delay any write.

## Interface
- `FB_W`, 320: framebuffer width in pixels (row pitch of the linear address).
- `FB_H`, 200: framebuffer height in pixels.
- `clk`  in  1: single system clock; all state updates on posedge.
- `rst_n`  in  1: reset is asynchronous and active-low.
- `start_fill`  in  1: one-cycle request pulse from the EPP interface.
- `fill_value`  in  1: pixel value to write; sampled with `start_fill`.
- `X1`  in  9: first corner x.
- `Y1`  in  8: first corner y.
- `X2`  in  9: opposite corner x.
- `Y2`  in  8: opposite corner y.
- `fb_we`  out  1: pixel write request.
- `fb_addr`  out  17: linear pixel address, y*FB_W + x.
- `fb_data`  out  1: pixel value.
- `fb_ack`  in  1: the write completes in any cycle where `fb_we && fb_ack`.
- `busy`  out  1: engine owns the framebuffer port.
- `done`  out  1: one-cycle pulse when the fill finishes.

## Operation
- States:
  - IDLE: accepts `start_fill`.
  - SETUP: normalises and clips the rectangle, computes the first row base.
  - WRITE: walks the pixels.
  - DONE: one cycle.
- IDLE with `start_fill`=1:
  - latch X1, Y1, X2, Y2 and `fill_value`;
  - go to SETUP.
- `start_fill` is ignored in every other state. There is no queueing.
- SETUP, normalise: x_lo=min(X1,X2), x_hi=max(X1,X2); y_lo and y_hi likewise.
- SETUP, clip: x_hi=min(x_hi,FB_W-1), y_hi=min(y_hi,FB_H-1).
- SETUP, empty rectangle: if x_lo>FB_W-1 or y_lo>FB_H-1, go to DONE with no writes.
- SETUP, otherwise:
  - cur_x=x_lo, cur_y=y_lo, row_base=y_lo*FB_W;
  - go to WRITE.
  - Compute row_base with shift-add, (y<<8)+(y<<6) for 320. No general multiplier.
- WRITE:
  - `fb_we`=1, `fb_addr`=row_base+cur_x, `fb_data`=latched value.
- On each completed write:
  - if cur_x<x_hi: cur_x+1;
  - else if cur_y<y_hi: cur_x=x_lo, cur_y+1, row_base+FB_W;
  - else: go to DONE.
- Inclusive corners: the write count is (x_hi-x_lo+1)*(y_hi-y_lo+1).
- Address arithmetic is 17-bit unsigned. The maximum address, 63999, never wraps.
- DONE: `done`=1 for one cycle, then IDLE.

## Timing
- Reset values:
  - state=IDLE;
  - `fb_we`=0, `fb_addr`=0, `fb_data`=0;
  - `busy`=0, `done`=0;
  - all latched coordinates 0.
- Start accepted at cycle N: SETUP is cycle N+1. The first `fb_we` is cycle N+2.
- `busy`=1 from cycle N+1 through the DONE cycle inclusive; it is 0 in IDLE.
- Throughput: one pixel per cycle while `fb_ack`=1.
- While `fb_we`=1 and `fb_ack`=0: `fb_addr` and `fb_data` hold stable, and `fb_we` stays high.
- `fb_we` drops in the cycle after the last ack, which is the DONE cycle.
- `fb_ack` outside WRITE is ignored.
- `done` fires the cycle after the final ack. For an empty rectangle it fires at cycle N+2.
- A new `start_fill` is accepted in IDLE, no earlier than one cycle after `done`.
- `rst_n` low mid-fill: immediately return to IDLE and force every output to its reset value.
  - The partial rectangle stays written.
  - No `done` pulse.
- Coordinate inputs may change freely after the start cycle. Only the latched copies are used.

## Test plan
- Single pixel: X1=X2=5, Y1=Y2=7, value 1, `fb_ack` tied 1.
  - Exactly one write, addr 2245, data 1.
  - `done` at start+3.
- Rectangle 20,40 to 100,100 with `fb_ack` tied 1: 81*61=4941 writes.
  - First addr 12820, last addr 32100, strictly row-major.
  - `done` the cycle after the last write.
- Swapped and clipped corners (300,190) to (10,250): normalised to x 10..300, y 190..199.
  - 2910 writes.
  - Last addr 63980.
- Off-screen X1=X2=400: zero writes; `busy` for 2 cycles; `done` at start+2.
- Random `fb_ack` stalls on a 4x3 fill:
  - address and data stay stable during stalls;
  - exactly 12 completed writes;
  - a second `start_fill` during busy is ignored.
- Assert `rst_n` low after 50 writes of a large fill:
  - outputs go to reset values at once; no `done`;
  - a following fill runs normally.

Source files
------------

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: latches two corners and a fill value, then writes
// every pixel of the inclusive, clipped rectangle to a 320x200 framebuffer
// port one pixel per acknowledged cycle.
module rect_fill_engine #(
    parameter int unsigned FB_W = 320,
    parameter int unsigned FB_H = 200
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start_fill,
    input  logic        i_fill_value,
    input  logic [8:0]  i_x1,
    input  logic [7:0]  i_y1,
    input  logic [8:0]  i_x2,
    input  logic [7:0]  i_y2,
    output logic        o_fb_we,
    output logic [16:0] o_fb_addr,
    output logic        o_fb_data,
    input  logic        i_fb_ack,
    output logic        o_busy,
    output logic        o_done
);

    localparam logic [8:0]  XMax     = 9'(FB_W - 1);
    localparam logic [7:0]  YMax     = 8'(FB_H - 1);
    localparam logic [16:0] RowPitch = 17'(FB_W);

    typedef enum logic [1:0] {StIdle, StSetup, StWrite, StDone} state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [8:0]  r_x1, r_x2;
    logic [7:0]  r_y1, r_y2;
    logic        r_val;
    logic [8:0]  r_x_lo, r_x_hi, r_cur_x;
    logic [7:0]  r_y_lo, r_y_hi, r_cur_y;
    logic [16:0] r_row_base;

    logic [8:0]  w_x_lo, w_x_hi, w_x_hi_clip;
    logic [7:0]  w_y_lo, w_y_hi, w_y_hi_clip;
    logic        w_empty;
    logic [16:0] w_row_base;
    logic        w_last_pixel;

    // Normalise and clip the latched corners; the low corners are not clipped
    // so a rectangle fully off-screen is detected as empty.
    always_comb begin
        w_x_lo      = (r_x1 < r_x2) ? r_x1 : r_x2;
        w_x_hi      = (r_x1 < r_x2) ? r_x2 : r_x1;
        w_y_lo      = (r_y1 < r_y2) ? r_y1 : r_y2;
        w_y_hi      = (r_y1 < r_y2) ? r_y2 : r_y1;
        w_x_hi_clip = (w_x_hi > XMax) ? XMax : w_x_hi;
        w_y_hi_clip = (w_y_hi > YMax) ? YMax : w_y_hi;
        w_empty     = (w_x_lo > XMax) || (w_y_lo > YMax);
        // y*320 as (y<<8)+(y<<6)
        w_row_base  = {1'b0, w_y_lo, 8'b0} + {3'b0, w_y_lo, 6'b0};
        w_last_pixel = (r_cur_x >= r_x_hi) && (r_cur_y >= r_y_hi);
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_state_next = r_state;
        o_fb_we      = 1'b0;
        o_fb_addr    = 17'd0;
        o_fb_data    = 1'b0;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_busy = 1'b0;
                if (i_start_fill) begin
                    w_state_next = StSetup;
                end
            end
            StSetup: begin
                w_state_next = w_empty ? StDone : StWrite;
            end
            StWrite: begin
                o_fb_we   = 1'b1;
                o_fb_addr = r_row_base + {8'b0, r_cur_x};
                o_fb_data = r_val;
                if (i_fb_ack && w_last_pixel) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                o_done       = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Latched request, normalised bounds and the pixel walk counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x1       <= '0;
            r_x2       <= '0;
            r_y1       <= '0;
            r_y2       <= '0;
            r_val      <= 1'b0;
            r_x_lo     <= '0;
            r_x_hi     <= '0;
            r_y_lo     <= '0;
            r_y_hi     <= '0;
            r_cur_x    <= '0;
            r_cur_y    <= '0;
            r_row_base <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start_fill) begin
                        r_x1  <= i_x1;
                        r_x2  <= i_x2;
                        r_y1  <= i_y1;
                        r_y2  <= i_y2;
                        r_val <= i_fill_value;
                    end
                end
                StSetup: begin
                    r_x_lo     <= w_x_lo;
                    r_x_hi     <= w_x_hi_clip;
                    r_y_lo     <= w_y_lo;
                    r_y_hi     <= w_y_hi_clip;
                    r_cur_x    <= w_x_lo;
                    r_cur_y    <= w_y_lo;
                    r_row_base <= w_row_base;
                end
                StWrite: begin
                    if (i_fb_ack) begin
                        if (r_cur_x < r_x_hi) begin
                            r_cur_x <= r_cur_x + 9'd1;
                        end else if (r_cur_y < r_y_hi) begin
                            r_cur_x    <= r_x_lo;
                            r_cur_y    <= r_cur_y + 8'd1;
                            r_row_base <= r_row_base + RowPitch;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
